dilithium_output_sequencer: RTL and testbench
=============================================

# dilithium_output_sequencer

Receives the Dilithium core's W-bit result stream after a keygen, sign or verify operation and splits it into tagged fields. Each output beat carries a field id, a word index within the field, field-last and frame-last flags. It sits between the core's output port and the testbench/host result checker. It is the consumer-side counterpart of the input loader that packs seeds, keys and messages into the core.

## Interface

Parameters:

- `W`, 32 — data word width; 32 (standard) or 64 (high-perf).
- `SEC_LEVEL`, 2 — Dilithium security level: 2, 3 or 5.

Ports:

- `clk` input 1 — clock.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — one-cycle pulse that begins a frame; sampled only in IDLE.
- `mode` input 2 — operation code, sampled with `start`: 00 = keygen, 10 = sign, 01 = verify, 11 = illegal.
- `in_data` input W — result word from the core.
- `in_valid` input 1 — `in_data` is valid.
- `in_ready` output 1 — sequencer accepts `in_data`.
- `out_data` output W — registered copy of the accepted word.
- `out_field` output 3 — field id of `out_data`.
- `out_idx` output 11 — word index of `out_data` within its field.
- `out_field_last` output 1 — `out_data` is the final word of its field.
- `out_frame_last` output 1 — `out_data` is the final word of the frame.
- `out_valid` output 1 — output beat valid.
- `out_ready` input 1 — downstream accepts the beat.
- `busy` output 1 — asserted in RUN and DRAIN.
- `mode_err` output 1 — sticky; set by `start` with mode 11, cleared by the next legal `start` or by reset.

## Operation

Field word counts are ceil(bits/W). Bit sizes per level (2/3/5):

- seed: 256
- s1: 3072/5120/5376
- s2: 3072/6144/6144
- t0: 13312/19968/26624
- t1: 10240/15360/20480
- z: 18432/25600/35840
- h: 672/488/664
- Example: level 2 with W=32 gives seed 8, s1 96, s2 96, t0 416, t1 320, z 576, h 21 words.

Field sequences:

- keygen: rho(0), key(1), tr(2) — each one seed — then s1(3), s2(4), t0(5), t1(6).
- sign: c(0, one seed), z(1), h(2).
- verify: one field, result(0), exactly 1 word.
- Field ids are per mode as listed.

States:

- IDLE: `in_ready`=0. On `start` with a legal mode, latch the mode, clear the field and word counters, clear `mode_err`, go to RUN. On `start` with mode 11, set `mode_err` and stay in IDLE.
- RUN: a word is accepted when `in_valid && in_ready`. It loads the output register with the current field id and index. The index increments; at field end the index wraps to 0 and the field id advances. Accepting the final frame word goes to DRAIN.
- DRAIN: `in_ready`=0. Wait for the final beat to be taken (`out_valid && out_ready`), then go to IDLE.
- `start` outside IDLE is ignored and has no side effects.

Output register:

- One entry.
- `in_ready` = (state==RUN) && (!out_valid || out_ready).
- Simultaneous take and accept in the same cycle reloads the register without a bubble.
- `out_*` fields are stable while `out_valid && !out_ready`.

## Timing

- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_field` 0, `out_idx` 0, both last flags 0, `busy` 0, `mode_err` 0; state IDLE.
- `start` at edge k gives RUN at k+1; `in_ready` can be high in cycle k+1.
- Latency from input accept to `out_valid` is 1 cycle. Throughput is 1 word/cycle with `out_ready` held high.
- `busy` rises the cycle after `start` and falls the cycle after the final beat handshake.
- Reset asserted mid-frame clears everything asynchronously. A partial frame is discarded and `out_valid` drops immediately.

## Test plan

- Reset mid-sign: assert `rst` after 100 words are accepted -> `out_valid`/`busy` low the same cycle. A fresh sign frame then outputs c idx 0 first.
- Keygen, level 2, W=32, `in_valid` and `out_ready` always 1 -> 952 beats. Field boundaries fall after beats 8/16/24/120/216/632. `out_frame_last` is asserted only on beat 952, field 6, idx 319. `busy` drops 1 cycle later.
- Sign, level 3, W=64, random `out_ready` stalls -> 4+400+8 beats, no data lost or duplicated. `out_*` holds during stalls, and `in_ready` stays low while stalled with `out_valid` high.
- Verify, level 5 -> exactly 1 beat: field 0, idx 0, both last flags set. Then IDLE; a second `in_valid` word is not accepted.
- `start` with mode 11 -> `mode_err`=1, `busy` stays 0. Then a `start` with mode 00 -> `mode_err`=0 and the frame runs.
- `start` pulsed during RUN with a different mode -> ignored; the frame completes with the original mode's field counts.

Source files
------------

// File: rtl/dilithium_output_sequencer.sv
// Splits the Dilithium core's result stream into tagged fields (field id, word index, last flags)
// behind a one-entry output register with valid/ready flow control on both sides.
module dilithium_output_sequencer #(
   parameter int W         = 32,
   parameter int SEC_LEVEL = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic [2:0]   out_field,
   output logic [10:0]  out_idx,
   output logic         out_field_last,
   output logic         out_frame_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         mode_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam int S1_BITS = (SEC_LEVEL == 2) ? 3072  : (SEC_LEVEL == 3) ? 5120  : 5376;
   localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
   localparam int T0_BITS = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;
   localparam int T1_BITS = (SEC_LEVEL == 2) ? 10240 : (SEC_LEVEL == 3) ? 15360 : 20480;
   localparam int Z_BITS  = (SEC_LEVEL == 2) ? 18432 : (SEC_LEVEL == 3) ? 25600 : 35840;
   localparam int H_BITS  = (SEC_LEVEL == 2) ? 672   : (SEC_LEVEL == 3) ? 488   : 664;

   // Word counts are ceil(bits/W).
   localparam logic [10:0] N_SEED = 11'((256     + W - 1) / W);
   localparam logic [10:0] N_S1   = 11'((S1_BITS + W - 1) / W);
   localparam logic [10:0] N_S2   = 11'((S2_BITS + W - 1) / W);
   localparam logic [10:0] N_T0   = 11'((T0_BITS + W - 1) / W);
   localparam logic [10:0] N_T1   = 11'((T1_BITS + W - 1) / W);
   localparam logic [10:0] N_Z    = 11'((Z_BITS  + W - 1) / W);
   localparam logic [10:0] N_H    = 11'((H_BITS  + W - 1) / W);

   state_t      state;
   logic [1:0]  mode_q;
   logic [2:0]  field_q;
   logic [10:0] idx_q;
   logic [10:0] field_len;
   logic [2:0]  last_field;
   logic        take;
   logic        accept;
   logic        field_end;
   logic        frame_end;

   // Length of the current field and id of the frame's final field for the latched mode.
   always_comb begin
      field_len  = 11'd1;
      last_field = 3'd0;
      case (mode_q)
         2'b00: begin
            last_field = 3'd6;
            case (field_q)
               3'd0, 3'd1, 3'd2: field_len = N_SEED;
               3'd3:             field_len = N_S1;
               3'd4:             field_len = N_S2;
               3'd5:             field_len = N_T0;
               default:          field_len = N_T1;
            endcase
         end
         2'b10: begin
            last_field = 3'd2;
            case (field_q)
               3'd0:    field_len = N_SEED;
               3'd1:    field_len = N_Z;
               default: field_len = N_H;
            endcase
         end
         default: begin
            field_len  = 11'd1;
            last_field = 3'd0;
         end
      endcase
   end

   // in_valid/in_ready and out_valid/out_ready each transfer a word on a cycle where both are high;
   // valid must hold with stable data until it is taken, ready may change freely.
   assign take      = out_valid && out_ready;
   assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign field_end = (idx_q == field_len - 11'd1);
   assign frame_end = field_end && (field_q == last_field);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         mode_q         <= 2'b00;
         field_q        <= 3'd0;
         idx_q          <= 11'd0;
         mode_err       <= 1'b0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_field      <= 3'd0;
         out_idx        <= 11'd0;
         out_field_last <= 1'b0;
         out_frame_last <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (mode == 2'b11) begin
                     mode_err <= 1'b1;
                  end else begin
                     mode_q   <= mode;
                     field_q  <= 3'd0;
                     idx_q    <= 11'd0;
                     mode_err <= 1'b0;
                     state    <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (take) out_valid <= 1'b0;
               // An accept in the same cycle as a take reloads the register, so no bubble appears.
               if (accept) begin
                  out_valid      <= 1'b1;
                  out_data       <= in_data;
                  out_field      <= field_q;
                  out_idx        <= idx_q;
                  out_field_last <= field_end;
                  out_frame_last <= frame_end;
                  if (field_end) begin
                     idx_q   <= 11'd0;
                     field_q <= field_q + 3'd1;
                  end else begin
                     idx_q <= idx_q + 11'd1;
                  end
                  if (frame_end) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (take) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dilithium_output_sequencer.sv
// Bench for dilithium_output_sequencer: three instances (W32/L2, W64/L3, W32/L5) driven with random
// words and stalls, checked against a field-table model and an expected-beat queue.
module tb_dilithium_output_sequencer;
   localparam int N       = 3;
   localparam int CYC_MAX = 8000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start          [N];
   logic [1:0]  mode           [N];
   logic [63:0] in_data        [N];
   logic        in_valid       [N];
   logic        out_ready      [N];
   logic        in_ready       [N];
   logic [2:0]  out_field      [N];
   logic [10:0] out_idx        [N];
   logic        out_field_last [N];
   logic        out_frame_last [N];
   logic        out_valid      [N];
   logic        busy           [N];
   logic        mode_err       [N];
   logic [31:0] od0;
   logic [63:0] od1;
   logic [31:0] od2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dilithium_output_sequencer #(.W(32), .SEC_LEVEL(2)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .in_data(in_data[0][31:0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(od0), .out_field(out_field[0]),
      .out_idx(out_idx[0]), .out_field_last(out_field_last[0]), .out_frame_last(out_frame_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]), .mode_err(mode_err[0]));

   dilithium_output_sequencer #(.W(64), .SEC_LEVEL(3)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .in_data(in_data[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(od1), .out_field(out_field[1]),
      .out_idx(out_idx[1]), .out_field_last(out_field_last[1]), .out_frame_last(out_frame_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]), .mode_err(mode_err[1]));

   dilithium_output_sequencer #(.W(32), .SEC_LEVEL(5)) dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .mode(mode[2]), .in_data(in_data[2][31:0]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_data(od2), .out_field(out_field[2]),
      .out_idx(out_idx[2]), .out_field_last(out_field_last[2]), .out_frame_last(out_frame_last[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]), .mode_err(mode_err[2]));

   function automatic int w_of(input int i);
      return (i == 1) ? 64 : 32;
   endfunction

   function automatic int lvl_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 3 : 5;
   endfunction

   function automatic int n_fields(input logic [1:0] m);
      if (m == 2'b00) return 7;
      if (m == 2'b10) return 3;
      return 1;
   endfunction

   // Bit size of field f in mode m; verify's single result word is modelled as 1 bit.
   function automatic int field_bits(input int lvl, input logic [1:0] m, input int f);
      if (m == 2'b01) return 1;
      if (m == 2'b10) begin
         if (f == 0) return 256;
         if (f == 1) return (lvl == 2) ? 18432 : (lvl == 3) ? 25600 : 35840;
         return (lvl == 2) ? 672 : (lvl == 3) ? 488 : 664;
      end
      if (f < 3)  return 256;
      if (f == 3) return (lvl == 2) ? 3072 : (lvl == 3) ? 5120 : 5376;
      if (f == 4) return (lvl == 2) ? 3072 : 6144;
      if (f == 5) return (lvl == 2) ? 13312 : (lvl == 3) ? 19968 : 26624;
      return (lvl == 2) ? 10240 : (lvl == 3) ? 15360 : 20480;
   endfunction

   function automatic logic [79:0] obs(input int i);
      logic [63:0] d;
      d = (i == 0) ? {32'd0, od0} : (i == 1) ? od1 : {32'd0, od2};
      return {out_field[i], out_idx[i], out_field_last[i], out_frame_last[i], d};
   endfunction

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a posedge; leaves the DUT in RUN (legal mode) one edge later.
   task automatic do_start(input int i, input logic [1:0] m);
      start[i] = 1'b1;
      mode[i]  = m;
      @(posedge clk); #1;
      start[i] = 1'b0;
   endtask

   task automatic run_frame(input int i, input logic [1:0] m, input bit rnd,
                            input int poke_cyc, input int abort_after);
      logic [15:0] tag_q[$];
      logic [79:0] exp_q[$];
      logic [79:0] snap;
      logic [63:0] mask;
      int          nf, len, total, acc, beats;
      bit          took_in, stall_prev;
      nf = n_fields(m);
      for (int f = 0; f < nf; f++) begin
         len = (field_bits(lvl_of(i), m, f) + w_of(i) - 1) / w_of(i);
         for (int k = 0; k < len; k++)
            tag_q.push_back({3'(f), 11'(k), (k == len - 1), (f == nf - 1 && k == len - 1)});
      end
      total = tag_q.size();
      mask  = (w_of(i) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      do_start(i, m);
      check("start_busy", 80'(busy[i]), 80'd1);
      check("start_mode_err", 80'(mode_err[i]), 80'd0);
      acc = 0; beats = 0; took_in = 1'b1; stall_prev = 1'b0; snap = '0;
      for (int cyc = 1; cyc <= CYC_MAX; cyc++) begin
         if (abort_after > 0 && acc == abort_after) begin
            rst = 1'b1; #1;
            check("rst_out_valid", 80'(out_valid[i]), 80'd0);
            check("rst_busy", 80'(busy[i]), 80'd0);
            check("rst_out_regs", obs(i), 80'd0);
            in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            return;
         end
         if (cyc == poke_cyc) begin
            start[i] = 1'b1;
            mode[i]  = 2'b00;
         end else begin
            start[i] = 1'b0;
         end
         if (!in_valid[i] || took_in) begin
            in_valid[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[i]  = {$urandom, $urandom} & mask;
         end
         out_ready[i] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         took_in = in_valid[i] && in_ready[i];
         if (stall_prev) check("hold_during_stall", obs(i), snap);
         if (out_valid[i] && !out_ready[i]) check("stall_in_ready", 80'(in_ready[i]), 80'd0);
         if (took_in) begin
            check("no_extra_word", 80'(acc < total), 80'd1);
            if (acc < total) exp_q.push_back({tag_q[acc], in_data[i]});
            acc++;
         end
         if (out_valid[i] && out_ready[i]) begin
            if (exp_q.size() == 0) check("beat_expected", 80'd0, 80'd1);
            else check("beat", obs(i), exp_q.pop_front());
            beats++;
            if (beats == total) begin
               check("drain_busy", 80'(busy[i]), 80'd1);
               if (!rnd) check("throughput_cycles", 80'(cyc), 80'(total + 1));
               @(posedge clk); #1;
               in_valid[i] = 1'b0;
               @(negedge clk);
               check("end_busy", 80'(busy[i]), 80'd0);
               check("end_out_valid", 80'(out_valid[i]), 80'd0);
               check("end_in_ready", 80'(in_ready[i]), 80'd0);
               @(posedge clk); #1;
               return;
            end
         end
         stall_prev = out_valid[i] && !out_ready[i];
         snap       = obs(i);
         @(posedge clk); #1;
      end
      check("frame_timeout_beats", 80'(beats), 80'(total));
      in_valid[i] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0; mode[i] = 2'b00; in_data[i] = '0;
         in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         check("reset_out_regs", obs(i), 80'd0);
         check("reset_flags", {76'd0, in_ready[i], out_valid[i], busy[i], mode_err[i]}, 80'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Illegal mode, then a legal keygen frame with no stalls.
      do_start(0, 2'b11);
      check("illegal_mode_err", 80'(mode_err[0]), 80'd1);
      check("illegal_busy", 80'(busy[0]), 80'd0);
      @(posedge clk); #1;
      check("illegal_still_idle", 80'(busy[0]), 80'd0);
      run_frame(0, 2'b00, 1'b0, 0, 0);

      // Sign with random stalls, an aborted sign, a fresh sign, and a sign with a stray start.
      run_frame(1, 2'b10, 1'b1, 0, 0);
      run_frame(1, 2'b10, 1'b1, 0, 100);
      run_frame(1, 2'b10, 1'b0, 0, 0);
      run_frame(1, 2'b10, 1'b1, 20, 0);

      // Verify: one beat, then further words are refused.
      run_frame(2, 2'b01, 1'b0, 0, 0);
      in_valid[2]  = 1'b1;
      in_data[2]   = {32'd0, $urandom};
      out_ready[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("verify_after_in_ready", 80'(in_ready[2]), 80'd0);
         check("verify_after_out_valid", 80'(out_valid[2]), 80'd0);
         @(posedge clk); #1;
      end
      in_valid[2] = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
